// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - control word layout shared by the Control decoder and ID/EX stage
//
// Purpose: one place for the control word width, its bit indices and the NOP encoding,
//          so the decoder and every pipeline stage agree on the layout.
// Ports:   none (package)

package mips_pkg;

  localparam int CTRL_W = 15;

  // Control word layout, MSB first:
  // {JR,Jal,Jump,Lui,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,ALUOp[2:0]}
  localparam int CTRL_JR       = 14;
  localparam int CTRL_JAL      = 13;
  localparam int CTRL_JUMP     = 12;
  localparam int CTRL_LUI      = 11;
  localparam int CTRL_REGDST   = 10;
  localparam int CTRL_ALUSRC   = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BNE      = 4;
  localparam int CTRL_BEQ      = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 0;

  typedef logic [CTRL_W-1:0] ctrlWord_t;

  // All-zero control word: no register write, no memory access, no branch.
  localparam ctrlWord_t CTRL_NOP = '0;

  function automatic logic isMemRead(input ctrlWord_t ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - combinational load-use hazard detector
//
// Purpose: flags when the instruction in ID reads the register that a load in EX
//          has not yet produced.
// Ports:
//   ex_memread  in   1           MemRead bit of the EX control word
//   ex_valid    in   1           EX holds a real instruction (0 = bubble)
//   ex_rt       in   REG_ADDR_W  destination of the load in EX
//   id_rs       in   REG_ADDR_W  rs of the instruction in ID
//   id_rt       in   REG_ADDR_W  rt of the instruction in ID
//   hazard      out  1           1 = ID must wait one cycle

module load_use_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_memread,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard
);

  logic loadInEx;
  logic destIsZero;
  logic srcMatch;

  assign loadInEx   = ex_memread & ex_valid;
  // $0 is hard-wired to zero, so a load "into" it never produces a value anyone waits on.
  assign destIsZero = (ex_rt == '0);
  assign srcMatch   = (ex_rt == id_rs) | (ex_rt == id_rt);

  assign hazard = loadInEx & ~destIsZero & srcMatch;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX pipeline register with load-use stall and bubble count
//
// Purpose: registers control word, operands and instruction fields for EX; inserts a
//          bubble on flush or load-use hazard and keeps a saturating bubble count.
// Ports:
//   clk           in   1           rising-edge clock
//   reset         in   1           asynchronous, active-low reset
//   id_ctrl       in   CTRL_W      control word from the decoder
//   id_pc4        in   DATA_WIDTH  PC+4 of the ID instruction
//   id_rd1/2      in   DATA_WIDTH  register file read data
//   id_imm        in   DATA_WIDTH  sign-extended immediate
//   id_rs/rt/rd   in   REG_ADDR_W  register specifiers
//   id_shamt      in   5           shift amount
//   id_funct      in   6           function field
//   flush         in   1           kill the ID instruction
//   ex_*          out  ...         registered copies of the id_* inputs
//   ex_valid      out  1           1 = real instruction in EX, 0 = bubble
//   stall         out  1           combinational; hold PC and IF/ID this cycle
//   bubble_count  out  CNT_W       bubbles inserted since reset, saturating

module id_ex_pipeline_register
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_WIDTH-1:0] id_pc4,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [4:0]            id_shamt,
  input  logic [5:0]            id_funct,
  input  logic                  flush,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [DATA_WIDTH-1:0] ex_pc4,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [5:0]            ex_funct,
  output logic                  ex_valid,
  output logic                  stall,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hazard;
  logic loadBubble;

  load_use_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_memread (isMemRead(ex_ctrl)),
    .ex_valid   (ex_valid),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard     (hazard)
  );

  // A flushed instruction is dead anyway, so there is nothing to hold upstream for.
  assign stall      = hazard & ~flush;
  assign loadBubble = flush | hazard;

  // Only the control word and valid bit are squashed on a bubble; the data fields
  // load as usual since nothing downstream acts on them without control bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl  <= CTRL_NOP;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_shamt <= '0;
      ex_funct <= '0;
    end else begin
      ex_ctrl  <= loadBubble ? CTRL_NOP : id_ctrl;
      ex_valid <= ~loadBubble;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_shamt <= id_shamt;
      ex_funct <= id_funct;
    end
  end

  // Saturating bubble counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_count <= '0;
    end else if (loadBubble && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - scoreboard bench for id_ex_pipeline_register

module tb_id_ex_pipeline_register;

  localparam logic [14:0] ADDI = 15'h284;
  localparam logic [14:0] LW   = 15'h3C0;
  localparam logic [14:0] ADD  = 15'h482;

  typedef struct {
    logic        chkMain;
    logic        isReset;
    logic [14:0] ctrl;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [15:0] count;
    logic        stall;
    logic [3:0]  count2;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [14:0] idCtrl = '0;
  logic [31:0] idPc4 = '0, idRd1 = '0, idRd2 = '0, idImm = '0;
  logic [4:0]  idRs = '0, idRt = '0, idRd = '0, idShamt = '0;
  logic [5:0]  idFunct = '0;

  logic [14:0] exCtrl;
  logic [31:0] exPc4, exRd1, exRd2, exImm;
  logic [4:0]  exRs, exRt, exRd, exShamt;
  logic [5:0]  exFunct;
  logic        exValid, stall;
  logic [15:0] bubbleCount;

  logic        reset2 = 1'b0;
  logic        flush2 = 1'b0;
  logic        nextReset2 = 1'b0;
  logic        nextFlush2 = 1'b0;
  logic        rstMid2 = 1'b0;
  logic [14:0] d2Ctrl;
  logic [31:0] d2Pc4, d2Rd1, d2Rd2, d2Imm;
  logic [4:0]  d2Rs, d2Rt, d2Rd, d2Shamt;
  logic [5:0]  d2Funct;
  logic        d2Valid, d2Stall;
  logic [3:0]  d2Count;

  int nChecks = 0;
  int nFail   = 0;
  item_t sb[$];

  id_ex_pipeline_register dut (
    .clk(clk), .reset(reset), .id_ctrl(idCtrl), .id_pc4(idPc4), .id_rd1(idRd1),
    .id_rd2(idRd2), .id_imm(idImm), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
    .id_shamt(idShamt), .id_funct(idFunct), .flush(flush), .ex_ctrl(exCtrl),
    .ex_pc4(exPc4), .ex_rd1(exRd1), .ex_rd2(exRd2), .ex_imm(exImm), .ex_rs(exRs),
    .ex_rt(exRt), .ex_rd(exRd), .ex_shamt(exShamt), .ex_funct(exFunct),
    .ex_valid(exValid), .stall(stall), .bubble_count(bubbleCount)
  );

  id_ex_pipeline_register #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset2), .id_ctrl(15'h0), .id_pc4(32'h0), .id_rd1(32'h0),
    .id_rd2(32'h0), .id_imm(32'h0), .id_rs(5'h0), .id_rt(5'h0), .id_rd(5'h0),
    .id_shamt(5'h0), .id_funct(6'h0), .flush(flush2), .ex_ctrl(d2Ctrl),
    .ex_pc4(d2Pc4), .ex_rd1(d2Rd1), .ex_rd2(d2Rd2), .ex_imm(d2Imm), .ex_rs(d2Rs),
    .ex_rt(d2Rt), .ex_rd(d2Rd), .ex_shamt(d2Shamt), .ex_funct(d2Funct),
    .ex_valid(d2Valid), .stall(d2Stall), .bubble_count(d2Count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t ex(input logic [14:0] c, input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [31:0] imm,
                               input logic [15:0] cnt, input logic st);
    item_t e;
    e.chkMain = 1'b1; e.isReset = 1'b0; e.ctrl = c; e.valid = v; e.rs = rs; e.rt = rt;
    e.imm = imm; e.count = cnt; e.stall = st; e.count2 = 4'd0;
    return e;
  endfunction

  function automatic item_t exRst();
    item_t e;
    e = ex(15'h0, 1'b0, 5'h0, 5'h0, 32'h0, 16'h0, 1'b0);
    e.isReset = 1'b1;
    return e;
  endfunction

  function automatic item_t exSat(input logic [3:0] c2);
    item_t e;
    e = exRst();
    e.chkMain = 1'b0;
    e.count2 = c2;
    return e;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue what the
  // monitor should see before the next rising edge.
  task automatic step(input logic rstVal, input logic rstMid, input logic fl,
                      input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] imm, input item_t e);
    @(posedge clk);
    #1;
    reset = rstVal; reset2 = nextReset2; flush2 = nextFlush2;
    flush = fl; idCtrl = c; idRs = rs; idRt = rt; idImm = imm;
    idPc4 = imm + 32'd4; idRd1 = imm ^ 32'hFFFF0000; idRd2 = ~imm;
    idRd = rt ^ 5'h1F; idShamt = rs; idFunct = {1'b0, rt};
    sb.push_back(e);
    #1;
    if (rstMid) reset = 1'b0;
    if (rstMid2) reset2 = 1'b0;
  endtask

  always @(negedge clk) begin
    item_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chkMain) begin
        chk("stall", 32'(stall), 32'(e.stall));
        chk("ex_valid", 32'(exValid), 32'(e.valid));
        chk("ex_ctrl", 32'(exCtrl), 32'(e.ctrl));
        chk("bubble_count", 32'(bubbleCount), 32'(e.count));
        if (e.isReset) begin
          chk("rst_data", exPc4 | exRd1 | exRd2 | exImm, 32'h0);
          chk("rst_fields", 32'({exRs, exRt, exRd, exShamt, exFunct}), 32'h0);
        end else if (e.valid) begin
          chk("ex_rs", 32'(exRs), 32'(e.rs));
          chk("ex_rt", 32'(exRt), 32'(e.rt));
          chk("ex_imm", exImm, e.imm);
          chk("ex_pc4", exPc4, e.imm + 32'd4);
          chk("ex_rd1", exRd1, e.imm ^ 32'hFFFF0000);
          chk("ex_rd2", exRd2, ~e.imm);
          chk("ex_rd", 32'(exRd), 32'(e.rt ^ 5'h1F));
          chk("ex_shamt", 32'(exShamt), 32'(e.rs));
          chk("ex_funct", 32'(exFunct), 32'({1'b0, e.rt}));
        end
      end
      chk("sat_count", 32'(d2Count), 32'(e.count2));
    end
  end

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 1'($urandom), 15'($urandom), 5'($urandom), 5'($urandom), $urandom, exRst());

    // addi, lw, load-use stall, $0, no-match, flush+hazard.
    step(1'b1, 1'b0, 1'b0, ADDI, 5'd0,  5'd8,  32'd5,      exRst());
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd9,  32'd0,      ex(ADDI, 1, 0, 8, 5, 0, 0));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd9,  5'd10, 32'h4820,   ex(LW, 1, 16, 9, 0, 0, 1));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd9,  5'd10, 32'h4820,   ex(15'h0, 0, 0, 0, 0, 1, 0));
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd0,  32'd4,      ex(ADD, 1, 9, 10, 32'h4820, 1, 0));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd0,  5'd0,  32'd1,      ex(LW, 1, 16, 0, 4, 1, 0));
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd9,  32'd8,      ex(ADD, 1, 0, 0, 1, 1, 0));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd10, 5'd11, 32'd2,      ex(LW, 1, 16, 9, 8, 1, 0));
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd9,  32'd12,     ex(ADD, 1, 10, 11, 2, 1, 0));
    step(1'b1, 1'b0, 1'b1, ADD,  5'd3,  5'd9,  32'd3,      ex(LW, 1, 16, 9, 12, 1, 0));
    step(1'b1, 1'b0, 1'b0, ADDI, 5'd0,  5'd8,  32'd7,      ex(15'h0, 0, 0, 0, 0, 2, 0));
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd9,  32'd16,     ex(ADDI, 1, 0, 8, 7, 2, 0));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd5,  5'd9,  32'd0,      ex(LW, 1, 16, 9, 16, 2, 1));
    step(1'b1, 1'b0, 1'b0, ADD,  5'd5,  5'd9,  32'd0,      ex(15'h0, 0, 0, 0, 0, 3, 0));
    step(1'b1, 1'b0, 1'b0, LW,   5'd16, 5'd9,  32'd20,     ex(ADD, 1, 5, 9, 0, 3, 0));
    // Async reset while the hazard is live: state and stall clear before any edge.
    step(1'b1, 1'b1, 1'b0, ADD,  5'd9,  5'd9,  32'd0,      exRst());
    step(1'b1, 1'b0, 1'b0, ADDI, 5'd0,  5'd8,  32'd9,      exRst());
    step(1'b1, 1'b0, 1'b0, ADD,  5'd1,  5'd2,  32'd3,      ex(ADDI, 1, 0, 8, 9, 0, 0));

    // Saturation on the 4-bit counter instance, then async reset mid-stream.
    nextReset2 = 1'b1;
    nextFlush2 = 1'b1;
    for (int k = 1; k <= 21; k++)
      step(1'b1, 1'b0, 1'b0, 15'h0, 5'd0, 5'd0, 32'd0, exSat((k - 1 > 15) ? 4'd15 : 4'(k - 1)));
    rstMid2 = 1'b1;
    step(1'b1, 1'b0, 1'b0, 15'h0, 5'd0, 5'd0, 32'd0, exSat(4'd0));
    rstMid2 = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
